// File: rtl/game_state_pkg.sv
// Shared types and default constants for the game-level state manager.
// Imported by the interface, the frame timer's user and the top.
package game_state_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_HIT,
        S_LEVEL_CLEAR,
        S_GAME_OVER
    } game_state_t;

    localparam int DEF_INIT_LIVES    = 3;
    localparam int DEF_INVULN_FRAMES = 60;
    localparam int DEF_CLEAR_FRAMES  = 90;
    localparam int DEF_BONUS_POINTS  = 100;
    localparam int DEF_GOAL_POINTS   = 1000;
    localparam int DEF_SCORE_W       = 16;
    localparam int DEF_LIVES_W       = 3;
    localparam int DEF_LEVEL_W       = 4;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] lim
    );
        logic [31:0] s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/game_state_manager_if.sv
// Collision pulses in, game state / HUD / mover controls out.
// master drives the pulses, slave is the state manager.
interface game_state_manager_if
    import game_state_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int LIVES_W = DEF_LIVES_W,
    parameter int LEVEL_W = DEF_LEVEL_W
);
    logic               startOfFrame;
    logic               start_pulse;
    logic               hit_damage;
    logic               hit_goal;
    logic               hit_bonus;
    game_state_t        state;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic [LEVEL_W-1:0] level;
    logic               freeze;
    logic               blink;
    logic               level_restart;

    modport master (
        output startOfFrame, start_pulse, hit_damage, hit_goal, hit_bonus,
        input  state, lives, score, level, freeze, blink, level_restart
    );

    modport slave (
        input  startOfFrame, start_pulse, hit_damage, hit_goal, hit_bonus,
        output state, lives, score, level, freeze, blink, level_restart
    );
endinterface

// File: rtl/game_state_manager_frame_timer.sv
// Frame-pulse counter with synchronous clear, enable and a
// terminal-count compare supplied by the user each cycle.
module frame_timer #(
    parameter int MAX = 90
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       clr,
    input  logic                       en,
    input  logic [$clog2(MAX+1)-1:0]   tc,
    output logic [$clog2(MAX+1)-1:0]   count,
    output logic                       done
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign done  = en && (cnt_q == tc);
endmodule

// File: rtl/game_state_manager.sv
// Game-level state: lives, saturating score, level, invulnerability
// window and level-clear / game-over pauses driven by hit pulses.
module game_state_manager
    import game_state_pkg::*;
#(
    parameter int INIT_LIVES    = DEF_INIT_LIVES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int CLEAR_FRAMES  = DEF_CLEAR_FRAMES,
    parameter int BONUS_POINTS  = DEF_BONUS_POINTS,
    parameter int GOAL_POINTS   = DEF_GOAL_POINTS,
    parameter int SCORE_W       = DEF_SCORE_W,
    parameter int LIVES_W       = DEF_LIVES_W,
    parameter int LEVEL_W       = DEF_LEVEL_W
) (
    input logic                 clk,
    input logic                 resetN,
    game_state_manager_if.slave bus
);
    localparam int CNT_MAX = (INVULN_FRAMES > CLEAR_FRAMES) ?
                             INVULN_FRAMES : CLEAR_FRAMES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    game_state_t        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               freeze_q, freeze_d;
    logic               restart_q, restart_d;
    logic [31:0]        sum;
    logic [CW-1:0]      cnt, tc;
    logic               tmr_clr, tmr_en, tmr_done;

    // One timer serves both pauses; the terminal count follows the state.
    assign tc = (state_q == S_HIT) ? CW'(INVULN_FRAMES - 1)
                                   : CW'(CLEAR_FRAMES - 1);
    assign tmr_en = bus.startOfFrame &&
                    (state_q == S_HIT || state_q == S_LEVEL_CLEAR);
    assign tmr_clr = (state_d != state_q);

    frame_timer #(.MAX(CNT_MAX)) u_timer (
        .clk   (clk),
        .resetN(resetN),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tc),
        .count (cnt),
        .done  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        level_d   = level_q;
        restart_d = 1'b0;
        sum = sat_add(32'(score_q),
                      bus.hit_bonus ? 32'(BONUS_POINTS) : 32'd0,
                      SCORE_MAX);
        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (bus.start_pulse) begin
                    state_d   = S_PLAY;
                    lives_d   = LIVES_W'(INIT_LIVES);
                    score_d   = '0;
                    level_d   = LEVEL_W'(1);
                    restart_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.hit_damage) begin
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = S_HIT;
                    end else begin
                        lives_d = '0;
                        state_d = S_GAME_OVER;
                    end
                end else if (bus.hit_goal) begin
                    sum     = sat_add(sum, 32'(GOAL_POINTS), SCORE_MAX);
                    state_d = S_LEVEL_CLEAR;
                end
                score_d = SCORE_W'(sum);
            end
            S_HIT: begin
                if (bus.hit_goal) begin
                    sum     = sat_add(sum, 32'(GOAL_POINTS), SCORE_MAX);
                    state_d = S_LEVEL_CLEAR;
                end else if (tmr_done) begin
                    state_d = S_PLAY;
                end
                score_d = SCORE_W'(sum);
            end
            S_LEVEL_CLEAR: begin
                if (tmr_done) begin
                    state_d   = S_PLAY;
                    restart_d = 1'b1;
                    level_d   = (level_q == {LEVEL_W{1'b1}}) ?
                                LEVEL_W'(1) : level_q + LEVEL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        freeze_d = !(state_d == S_PLAY || state_d == S_HIT);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            lives_q   <= LIVES_W'(INIT_LIVES);
            score_q   <= '0;
            level_q   <= LEVEL_W'(1);
            freeze_q  <= 1'b1;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            level_q   <= level_d;
            freeze_q  <= freeze_d;
            restart_q <= restart_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.lives         = lives_q;
    assign bus.score         = score_q;
    assign bus.level         = level_q;
    assign bus.freeze        = freeze_q;
    assign bus.blink         = (state_q == S_HIT) && cnt[2];
    assign bus.level_restart = restart_q;
endmodule

// File: tb/tb_game_state_manager.sv
// Scoreboard bench: a behavioural game model queues expected outputs,
// plus directed checks and an 8-bit-score saturation instance.
module tb_game_state_manager;
    import game_state_pkg::*;

    logic clk    = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    game_state_manager_if #(.SCORE_W(16), .LIVES_W(3), .LEVEL_W(4)) a_if ();
    game_state_manager_if #(.SCORE_W(8),  .LIVES_W(3), .LEVEL_W(4)) b_if ();

    game_state_manager #(.SCORE_W(16)) dut_a (
        .clk   (clk),
        .resetN(resetN),
        .bus   (a_if.slave)
    );

    game_state_manager #(.SCORE_W(8)) dut_b (
        .clk   (clk),
        .resetN(resetN),
        .bus   (b_if.slave)
    );

    typedef struct {
        int st; int lv; int sc; int lvl; int frz; int blk; int rs;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int m_st, m_lv, m_sc, m_lvl, m_cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_lv = 3; m_sc = 0; m_lvl = 1; m_cnt = 0;
    endtask

    task automatic model_step(input bit sof, input bit st, input bit dmg,
                              input bit goal, input bit bon);
        exp_t e;
        int rs;
        rs = 0;
        case (m_st)
            0, 4: if (st) begin
                m_st = 1; m_lv = 3; m_sc = 0; m_lvl = 1; rs = 1;
            end
            1: begin
                if (bon) m_sc = sat16(m_sc + 100);
                if (dmg) begin
                    if (m_lv > 1) begin m_lv--; m_st = 2; m_cnt = 0; end
                    else begin m_lv = 0; m_st = 4; end
                end else if (goal) begin
                    m_sc = sat16(m_sc + 1000); m_st = 3; m_cnt = 0;
                end
            end
            2: begin
                if (bon) m_sc = sat16(m_sc + 100);
                if (goal) begin
                    m_sc = sat16(m_sc + 1000); m_st = 3; m_cnt = 0;
                end else if (sof) begin
                    if (m_cnt == 59) m_st = 1;
                    else m_cnt++;
                end
            end
            3: if (sof) begin
                if (m_cnt == 89) begin
                    m_st = 1; rs = 1;
                    m_lvl = (m_lvl == 15) ? 1 : m_lvl + 1;
                end else m_cnt++;
            end
            default: ;
        endcase
        e.st  = m_st; e.lv = m_lv; e.sc = m_sc; e.lvl = m_lvl; e.rs = rs;
        e.frz = (m_st == 0 || m_st == 3 || m_st == 4) ? 1 : 0;
        e.blk = (m_st == 2) ? ((m_cnt >> 2) & 1) : 0;
        q.push_back(e);
    endtask

    task automatic cyc(input bit sof, input bit st, input bit dmg,
                       input bit goal, input bit bon);
        exp_t e;
        a_if.startOfFrame = sof;
        a_if.start_pulse  = st;
        a_if.hit_damage   = dmg;
        a_if.hit_goal     = goal;
        a_if.hit_bonus    = bon;
        model_step(sof, st, dmg, goal, bon);
        @(posedge clk);
        #1;
        a_if.startOfFrame = 1'b0;
        a_if.start_pulse  = 1'b0;
        a_if.hit_damage   = 1'b0;
        a_if.hit_goal     = 1'b0;
        a_if.hit_bonus    = 1'b0;
        e = q.pop_front();
        check("state",   32'(a_if.state),         32'(e.st));
        check("lives",   32'(a_if.lives),         32'(e.lv));
        check("score",   32'(a_if.score),         32'(e.sc));
        check("level",   32'(a_if.level),         32'(e.lvl));
        check("freeze",  32'(a_if.freeze),        32'(e.frz));
        check("blink",   32'(a_if.blink),         32'(e.blk));
        check("restart", 32'(a_if.level_restart), 32'(e.rs));
    endtask

    task automatic frames(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0, 0);
            for (int j = 0; j < gap; j++) cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic cyc_b(input bit st, input bit goal, input bit bon);
        b_if.start_pulse = st;
        b_if.hit_goal    = goal;
        b_if.hit_bonus   = bon;
        cyc(0, 0, 0, 0, 0);
        b_if.start_pulse = 1'b0;
        b_if.hit_goal    = 1'b0;
        b_if.hit_bonus   = 1'b0;
    endtask

    task automatic check_reset(input string who, input logic [2:0] st,
                               input logic [2:0] lv, input logic [15:0] sc,
                               input logic [3:0] lvl, input logic frz,
                               input logic blk, input logic rs);
        check({who, "_rst_state"},   32'(st),  32'(S_IDLE));
        check({who, "_rst_lives"},   32'(lv),  32'd3);
        check({who, "_rst_score"},   32'(sc),  32'd0);
        check({who, "_rst_level"},   32'(lvl), 32'd1);
        check({who, "_rst_freeze"},  32'(frz), 32'd1);
        check({who, "_rst_blink"},   32'(blk), 32'd0);
        check({who, "_rst_restart"}, 32'(rs),  32'd0);
    endtask

    initial begin
        a_if.startOfFrame = 0; a_if.start_pulse = 0; a_if.hit_damage = 0;
        a_if.hit_goal = 0; a_if.hit_bonus = 0;
        b_if.startOfFrame = 0; b_if.start_pulse = 0; b_if.hit_damage = 0;
        b_if.hit_goal = 0; b_if.hit_bonus = 0;
        model_reset();
        #1 resetN = 1'b0;
        #10;
        check_reset("a", a_if.state, a_if.lives, a_if.score, a_if.level,
                    a_if.freeze, a_if.blink, a_if.level_restart);
        #1 resetN = 1'b1;
        @(posedge clk);
        #1;

        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        check("idle_hits_ignored", 32'(a_if.state), 32'(S_IDLE));

        cyc(0, 1, 0, 0, 0);
        check("start_state",   32'(a_if.state),         32'(S_PLAY));
        check("start_lives",   32'(a_if.lives),         32'd3);
        check("start_restart", 32'(a_if.level_restart), 32'd1);
        check("start_freeze",  32'(a_if.freeze),        32'd0);
        cyc(0, 0, 0, 0, 0);
        check("restart_one_cycle", 32'(a_if.level_restart), 32'd0);

        cyc(0, 0, 1, 0, 0);
        check("dmg1_lives", 32'(a_if.lives), 32'd2);
        check("dmg1_state", 32'(a_if.state), 32'(S_HIT));
        frames(10, 1);
        cyc(0, 0, 1, 0, 0);
        check("invuln_dmg_ignored", 32'(a_if.lives), 32'd2);
        cyc(0, 1, 0, 0, 0);
        frames(49, 1);
        check("hit_after_59", 32'(a_if.state), 32'(S_HIT));
        frames(1, 0);
        check("hit_after_60", 32'(a_if.state), 32'(S_PLAY));
        check("blink_off",    32'(a_if.blink), 32'd0);

        cyc(0, 0, 1, 0, 0);
        check("dmg2_lives", 32'(a_if.lives), 32'd1);
        frames(60, 0);
        cyc(0, 0, 1, 0, 0);
        check("dmg3_lives",  32'(a_if.lives),  32'd0);
        check("dmg3_state",  32'(a_if.state),  32'(S_GAME_OVER));
        check("dmg3_freeze", 32'(a_if.freeze), 32'd1);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 0);
        check("restart_lives", 32'(a_if.lives), 32'd3);
        check("restart_score", 32'(a_if.score), 32'd0);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0);
        end
        check("bonus_x3", 32'(a_if.score), 32'd300);
        cyc(0, 0, 0, 1, 0);
        check("goal_score", 32'(a_if.score), 32'd1300);
        check("goal_state", 32'(a_if.state), 32'(S_LEVEL_CLEAR));
        cyc(0, 1, 0, 0, 0);
        frames(89, 0);
        check("clear_after_89", 32'(a_if.state), 32'(S_LEVEL_CLEAR));
        cyc(1, 0, 0, 0, 0);
        check("clear_level",   32'(a_if.level),         32'd2);
        check("clear_restart", 32'(a_if.level_restart), 32'd1);
        check("clear_score",   32'(a_if.score),         32'd1300);
        cyc(0, 0, 0, 0, 0);

        cyc(0, 0, 1, 1, 1);
        check("combo_state", 32'(a_if.state), 32'(S_HIT));
        check("combo_lives", 32'(a_if.lives), 32'd2);
        check("combo_score", 32'(a_if.score), 32'd1400);
        frames(5, 0);
        cyc(1, 0, 0, 1, 0);
        check("hit_goal_state", 32'(a_if.state), 32'(S_LEVEL_CLEAR));
        frames(90, 0);

        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 1, 0);
            frames(90, 0);
        end
        check("level_15", 32'(a_if.level), 32'd15);
        cyc(0, 0, 0, 1, 0);
        frames(90, 0);
        check("level_wrap", 32'(a_if.level), 32'd1);

        cyc_b(1, 0, 0);
        check("b_start", 32'(b_if.state), 32'(S_PLAY));
        cyc_b(0, 0, 1);
        cyc_b(0, 0, 1);
        check("b_score_200", 32'(b_if.score), 32'd200);
        cyc_b(0, 0, 1);
        check("b_score_sat", 32'(b_if.score), 32'd255);
        cyc_b(0, 1, 0);
        check("b_goal_sat",  32'(b_if.score), 32'd255);
        check("b_goal_state", 32'(b_if.state), 32'(S_LEVEL_CLEAR));

        cyc(0, 0, 0, 1, 0);
        frames(5, 0);
        resetN = 1'b0;
        #2;
        model_reset();
        check_reset("a", a_if.state, a_if.lives, a_if.score, a_if.level,
                    a_if.freeze, a_if.blink, a_if.level_restart);
        check_reset("b", b_if.state, b_if.lives, 16'(b_if.score), b_if.level,
                    b_if.freeze, b_if.blink, b_if.level_restart);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(2) == 0, $urandom_range(24) == 0,
                $urandom_range(19) == 0, $urandom_range(29) == 0,
                $urandom_range(7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
